// File: rtl/column_pkg.sv
// Shared types, constants and helpers for the column bank scheduler.
package column_pkg;

  localparam int unsigned NUM_COLS_DEF = 640;
  localparam int unsigned COL_W        = 10;

  typedef logic [1:0]  bank_idx_t;
  typedef logic [41:0] coldata_t;
  typedef logic [15:0] sf_t;

  // Host status word bit positions
  localparam int unsigned ST_RD_LSB   = 0;
  localparam int unsigned ST_WR_LSB   = 2;
  localparam int unsigned ST_PEND_LSB = 4;
  localparam int unsigned ST_PV_BIT   = 6;
  localparam int unsigned ST_RDY_BIT  = 7;
  localparam int unsigned ST_DROP_LSB = 8;

  // The bank that is neither a nor b (a != b assumed)
  function automatic bank_idx_t third_bank(input bank_idx_t a, input bank_idx_t b);
    return 2'd3 ^ a ^ b;
  endfunction

endpackage

// File: rtl/column_bank_scheduler_if.sv
// Host-side and bank-side signal bundle of the column bank scheduler.
interface column_bank_scheduler_if;
  import column_pkg::*;

  logic                   host_start;
  logic                   host_wr;
  logic [15:0]            host_data;
  logic                   host_ready;
  logic                   frame_boundary;
  logic [2:0]             bank_wr_en;
  logic [COL_W-1:0]       bank_wr_col;
  coldata_t               bank_wr_coldata;
  sf_t                    bank_wr_sf;
  bank_idx_t              rd_bank;
  logic [15:0]            status;

  modport master (
    output host_start, host_wr, host_data, frame_boundary,
    input  host_ready, bank_wr_en, bank_wr_col, bank_wr_coldata, bank_wr_sf, rd_bank, status
  );

  modport slave (
    input  host_start, host_wr, host_data, frame_boundary,
    output host_ready, bank_wr_en, bank_wr_col, bank_wr_coldata, bank_wr_sf, rd_bank, status
  );

endinterface

// File: rtl/column_word_assembler.sv
// Collects four host words per column record and tracks the column position in the frame.
module column_word_assembler
  import column_pkg::*;
#(
  parameter int unsigned NUM_COLS = NUM_COLS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             accept_i,
  input  logic [15:0]      word_i,
  output logic [COL_W-1:0] col_o,
  output coldata_t         coldata_o,
  output logic             last_word_o,
  output logic             col_done_o,
  output logic             frame_done_o
);

  logic [1:0]       stage_q, stage_d;
  logic [COL_W-1:0] col_q, col_d;
  coldata_t         data_q, data_d;
  logic             last_col;

  assign last_col     = (col_q == COL_W'(NUM_COLS - 1));
  assign last_word_o  = (stage_q == 2'd3) && last_col;
  assign col_done_o   = accept_i && (stage_q == 2'd3);
  assign frame_done_o = col_done_o && last_col;
  assign col_o        = col_q;
  assign coldata_o    = data_q;

  // Next-state: start discards the partial column, otherwise steer the word by stage
  always_comb begin
    stage_d = stage_q;
    col_d   = col_q;
    data_d  = data_q;
    if (start_i) begin
      stage_d = 2'd0;
      col_d   = '0;
    end else if (accept_i) begin
      stage_d = stage_q + 2'd1;
      unique case (stage_q)
        2'd0: data_d[9:0]   = word_i[9:0];
        2'd1: data_d[25:10] = word_i;
        2'd2: data_d[41:26] = word_i;
        2'd3: col_d         = last_col ? '0 : col_q + COL_W'(1);
      endcase
    end
  end

  // Stage, column and data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= 2'd0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      stage_q <= stage_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/column_bank_scheduler.sv
// Triple-buffered column bank scheduler: assembles column records, steers them into the write
// bank and swaps the read bank only at frame boundaries.
// Build option: define COLUMN_BANK_STALL_EN to stall the final word of a frame instead of
// dropping a pending frame.
module column_bank_scheduler
  import column_pkg::*;
#(
  parameter int unsigned NUM_COLS = NUM_COLS_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  column_bank_scheduler_if.slave  bus
);

  logic             accept, col_done, frame_done, last_word, host_ready;
  logic [COL_W-1:0] col;
  coldata_t         coldata;

  bank_idx_t        r_q, r_d, w_q, w_d, p_q, p_d;
  logic             pv_q, pv_d;
  logic             drop_inc;
  logic [CNT_W-1:0] drop_cnt;

  logic [2:0]       en_q;
  logic [COL_W-1:0] wcol_q;
  coldata_t         wdata_q;
  sf_t              sf_q;

  assign accept = bus.host_wr && host_ready && !bus.host_start;

  column_word_assembler #(
    .NUM_COLS (NUM_COLS)
  ) u_asm (
    .clk          (clk),
    .reset        (reset),
    .start_i      (bus.host_start),
    .accept_i     (accept),
    .word_i       (bus.host_data),
    .col_o        (col),
    .coldata_o    (coldata),
    .last_word_o  (last_word),
    .col_done_o   (col_done),
    .frame_done_o (frame_done)
  );

  // Bank rotation; commit and frame boundary are both judged on pre-edge state
  always_comb begin
    r_d      = r_q;
    w_d      = w_q;
    p_d      = p_q;
    pv_d     = pv_q;
    drop_inc = 1'b0;
    if (frame_done && bus.frame_boundary) begin
      if (pv_q) begin
        r_d = p_q;
        p_d = w_q;
        w_d = r_q;
      end else begin
        r_d = w_q;
        w_d = third_bank(r_q, w_q);
      end
    end else if (frame_done) begin
      p_d  = w_q;
      pv_d = 1'b1;
      if (pv_q) begin
        w_d      = p_q;
        drop_inc = 1'b1;
      end else begin
        w_d = third_bank(r_q, w_q);
      end
    end else if (bus.frame_boundary && pv_q) begin
      r_d  = p_q;
      pv_d = 1'b0;
    end
  end

  // Bank state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q  <= 2'd0;
      w_q  <= 2'd1;
      p_q  <= 2'd2;
      pv_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      w_q  <= w_d;
      p_q  <= p_d;
      pv_q <= pv_d;
    end
  end

`ifdef COLUMN_BANK_STALL_EN
  // Hold off the final word while a committed frame still waits for display
  assign host_ready = !(last_word && pv_q);
  assign drop_cnt   = '0;

  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
`else
  assign host_ready = 1'b1;

  logic unused_last_word;
  assign unused_last_word = last_word;

  logic [CNT_W-1:0] drop_q;
  assign drop_cnt = drop_q;

  // Saturating count of pending frames overwritten before display
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end
`endif

  // Bank write port, one cycle after the w3 edge; bank index is the pre-commit write bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= 3'b000;
      wcol_q  <= '0;
      wdata_q <= '0;
      sf_q    <= '0;
    end else begin
      en_q <= col_done ? (3'b001 << w_q) : 3'b000;
      if (col_done) begin
        wcol_q  <= col;
        wdata_q <= coldata;
        sf_q    <= bus.host_data;
      end
    end
  end

  // Output and status assembly
  always_comb begin
    bus.status                        = '0;
    bus.status[ST_RD_LSB +: 2]        = r_q;
    bus.status[ST_WR_LSB +: 2]        = w_q;
    bus.status[ST_PEND_LSB +: 2]      = p_q;
    bus.status[ST_PV_BIT]             = pv_q;
    bus.status[ST_RDY_BIT]            = host_ready;
    bus.status[ST_DROP_LSB +: 8]      = 8'(drop_cnt);
  end

  assign bus.host_ready      = host_ready;
  assign bus.bank_wr_en      = en_q;
  assign bus.bank_wr_col     = wcol_q;
  assign bus.bank_wr_coldata = wdata_q;
  assign bus.bank_wr_sf      = sf_q;
  assign bus.rd_bank         = r_q;

endmodule

// File: tb/tb_column_bank_scheduler.sv
// Directed self-checking bench for column_bank_scheduler.
module tb_column_bank_scheduler;
  import column_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  column_bank_scheduler_if bus ();

  column_bank_scheduler #(
    .NUM_COLS (640),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] w0f(input int c);
    return {6'h2A, 10'(c)};
  endfunction
  function automatic logic [15:0] w1f(input int c);
    return 16'h1000 ^ 16'(c);
  endfunction
  function automatic logic [15:0] w2f(input int c);
    return 16'h2000 + 16'(c);
  endfunction
  function automatic logic [15:0] w3f(input int c);
    return 16'h3000 + 16'(c);
  endfunction
  function automatic coldata_t exp_data(input int c);
    return {w2f(c), w1f(c), 10'(c)};
  endfunction

  task automatic put_word(input logic [15:0] d);
    @(negedge clk);
    bus.host_wr   = 1'b1;
    bus.host_data = d;
  endtask

  // One full column with seed c, expected to land at column c; optional boundary on w3
  task automatic send_col(input int c, input logic [2:0] exp_en, input bit fb);
    put_word(w0f(c));
    put_word(w1f(c));
    put_word(w2f(c));
    put_word(w3f(c));
    bus.frame_boundary = fb;
    @(negedge clk);
    bus.host_wr        = 1'b0;
    bus.frame_boundary = 1'b0;
    checks++;
    if (bus.bank_wr_en !== exp_en || bus.bank_wr_col !== 10'(c) ||
        bus.bank_wr_coldata !== exp_data(c) || bus.bank_wr_sf !== w3f(c)) begin
      errors++;
      $display("FAIL col_write c=%0d: got en=%b col=%0d data=%h sf=%h, want en=%b data=%h sf=%h",
               c, bus.bank_wr_en, bus.bank_wr_col, bus.bank_wr_coldata, bus.bank_wr_sf,
               exp_en, exp_data(c), w3f(c));
    end
  endtask

  task automatic send_cols(input int first, input int last, input logic [2:0] exp_en);
    for (int c = first; c <= last; c++) send_col(c, exp_en, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.status !== 16'h00A4 || bus.rd_bank !== 2'd0 || bus.bank_wr_en !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got status=%h rd=%0d en=%b, want 00a4 0 000",
               bus.status, bus.rd_bank, bus.bank_wr_en);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.rd_bank !== 2'd0) begin
      errors++;
      $display("FAIL reset_rd_bank: got %0d want 0", bus.rd_bank);
    end
    checks++;
    if (bus.status !== 16'h00A4) begin
      errors++;
      $display("FAIL reset_status: got %h want 00a4", bus.status);
    end
    checks++;
    if (bus.bank_wr_en !== 3'b000 || bus.bank_wr_col !== 10'd0 ||
        bus.bank_wr_coldata !== 42'd0 || bus.bank_wr_sf !== 16'd0) begin
      errors++;
      $display("FAIL reset_write_port: got en=%b col=%0d data=%h sf=%h want all zero",
               bus.bank_wr_en, bus.bank_wr_col, bus.bank_wr_coldata, bus.bank_wr_sf);
    end
    checks++;
    if (bus.host_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_host_ready: got %b want 1", bus.host_ready);
    end
  endtask

  task automatic test_frame();
    send_cols(0, 639, 3'b010);
    checks++;
    if (bus.status !== 16'h00D8 || bus.rd_bank !== 2'd0) begin
      errors++;
      $display("FAIL frame_commit: got status=%h rd=%0d want 00d8 0", bus.status, bus.rd_bank);
    end
  endtask

  task automatic test_boundary();
    @(negedge clk);
    bus.frame_boundary = 1'b1;
    @(negedge clk);
    bus.frame_boundary = 1'b0;
    checks++;
    if (bus.status !== 16'h0099 || bus.rd_bank !== 2'd1) begin
      errors++;
      $display("FAIL boundary_swap: got status=%h rd=%0d want 0099 1", bus.status, bus.rd_bank);
    end
    @(negedge clk);
    bus.frame_boundary = 1'b1;
    @(negedge clk);
    bus.frame_boundary = 1'b0;
    checks++;
    if (bus.status !== 16'h0099 || bus.rd_bank !== 2'd1) begin
      errors++;
      $display("FAIL boundary_idle: got status=%h rd=%0d want 0099 1", bus.status, bus.rd_bank);
    end
  endtask

  task automatic test_two_frames();
    do_reset();
    send_cols(0, 639, 3'b010);
`ifdef COLUMN_BANK_STALL_EN
    send_cols(0, 638, 3'b100);
    put_word(w0f(639));
    put_word(w1f(639));
    put_word(w2f(639));
    put_word(w3f(639));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.host_ready !== 1'b0 || bus.bank_wr_en !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold: got ready=%b en=%b want 0 000", bus.host_ready, bus.bank_wr_en);
      end
    end
    bus.frame_boundary = 1'b1;
    @(negedge clk);
    bus.frame_boundary = 1'b0;
    checks++;
    if (bus.host_ready !== 1'b1 || bus.rd_bank !== 2'd1) begin
      errors++;
      $display("FAIL stall_release: got ready=%b rd=%0d want 1 1", bus.host_ready, bus.rd_bank);
    end
    @(negedge clk);
    bus.host_wr = 1'b0;
    checks++;
    if (bus.bank_wr_en !== 3'b100 || bus.bank_wr_col !== 10'd639 || bus.status !== 16'h00E1) begin
      errors++;
      $display("FAIL stall_commit: got en=%b col=%0d status=%h want 100 639 00e1",
               bus.bank_wr_en, bus.bank_wr_col, bus.status);
    end
`else
    send_cols(0, 639, 3'b100);
    checks++;
    if (bus.status !== 16'h01E4 || bus.rd_bank !== 2'd0) begin
      errors++;
      $display("FAIL drop_frame: got status=%h rd=%0d want 01e4 0", bus.status, bus.rd_bank);
    end
`endif
  endtask

  task automatic test_host_start();
`ifdef COLUMN_BANK_STALL_EN
    logic [2:0]  en    = 3'b001;
    logic [15:0] st_ex = 16'h00E1;
`else
    logic [2:0]  en    = 3'b010;
    logic [15:0] st_ex = 16'h01E4;
`endif
    send_cols(0, 4, en);
    put_word(w0f(5));
    put_word(w1f(5));
    put_word(w2f(5));
    @(negedge clk);
    bus.host_start = 1'b1;
    bus.host_wr    = 1'b1;
    bus.host_data  = 16'hFFFF;
    @(negedge clk);
    bus.host_start = 1'b0;
    bus.host_wr    = 1'b0;
    checks++;
    if (bus.bank_wr_en !== 3'b000 || bus.status !== st_ex) begin
      errors++;
      $display("FAIL start_no_write: got en=%b status=%h want 000 %h",
               bus.bank_wr_en, bus.status, st_ex);
    end
    put_word(w0f(100));
    put_word(w1f(100));
    put_word(w2f(100));
    put_word(w3f(100));
    @(negedge clk);
    bus.host_wr = 1'b0;
    checks++;
    if (bus.bank_wr_en !== en || bus.bank_wr_col !== 10'd0 ||
        bus.bank_wr_coldata !== exp_data(100) || bus.bank_wr_sf !== w3f(100)) begin
      errors++;
      $display("FAIL start_restart: got en=%b col=%0d data=%h sf=%h want %b 0 %h %h",
               bus.bank_wr_en, bus.bank_wr_col, bus.bank_wr_coldata, bus.bank_wr_sf,
               en, exp_data(100), w3f(100));
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    send_cols(0, 638, 3'b010);
    send_col(639, 3'b010, 1'b1);
    checks++;
    if (bus.status !== 16'h00A9 || bus.rd_bank !== 2'd1) begin
      errors++;
      $display("FAIL same_cycle_nopend: got status=%h rd=%0d want 00a9 1",
               bus.status, bus.rd_bank);
    end
    send_cols(0, 639, 3'b100);
    checks++;
    if (bus.status !== 16'h00E1) begin
      errors++;
      $display("FAIL same_cycle_setup: got status=%h want 00e1", bus.status);
    end
`ifndef COLUMN_BANK_STALL_EN
    send_cols(0, 638, 3'b001);
    send_col(639, 3'b001, 1'b1);
    checks++;
    if (bus.status !== 16'h00C6 || bus.rd_bank !== 2'd2) begin
      errors++;
      $display("FAIL same_cycle_pend: got status=%h rd=%0d want 00c6 2",
               bus.status, bus.rd_bank);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    put_word(w0f(7));
    put_word(w1f(7));
    put_word(w2f(7));
    put_word(w3f(7));
    put_word(w0f(8));
    checks++;
    if (bus.bank_wr_en !== 3'b010 || bus.bank_wr_col !== 10'd0 ||
        bus.bank_wr_coldata !== exp_data(7) || bus.bank_wr_sf !== w3f(7)) begin
      errors++;
      $display("FAIL b2b_first: got en=%b col=%0d data=%h sf=%h want 010 0 %h %h",
               bus.bank_wr_en, bus.bank_wr_col, bus.bank_wr_coldata, bus.bank_wr_sf,
               exp_data(7), w3f(7));
    end
    put_word(w1f(8));
    checks++;
    if (bus.bank_wr_en !== 3'b000) begin
      errors++;
      $display("FAIL b2b_pulse_width: got en=%b want 000", bus.bank_wr_en);
    end
    put_word(w2f(8));
    put_word(w3f(8));
    @(negedge clk);
    bus.host_wr = 1'b0;
    checks++;
    if (bus.bank_wr_en !== 3'b010 || bus.bank_wr_col !== 10'd1 ||
        bus.bank_wr_coldata !== exp_data(8) || bus.bank_wr_sf !== w3f(8)) begin
      errors++;
      $display("FAIL b2b_second: got en=%b col=%0d data=%h sf=%h want 010 1 %h %h",
               bus.bank_wr_en, bus.bank_wr_col, bus.bank_wr_coldata, bus.bank_wr_sf,
               exp_data(8), w3f(8));
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.host_start     = 1'b0;
    bus.host_wr        = 1'b0;
    bus.host_data      = 16'h0000;
    bus.frame_boundary = 1'b0;
    test_reset();
    test_frame();
    test_boundary();
    test_two_frames();
    test_host_start();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_bank_scheduler.md
# column_bank_scheduler

Sequences the triple-buffered column store feeding the ray-cast column decoder. It assembles 16-bit host words into column records, steers each record into the current write bank, and commits completed frames. It swaps the display read bank only at the frame boundary, so the pixel pipeline never reads a partially written frame. It sits between the Avalon register decode and the three column banks.

## Interface
- NUM_COLS, 640: columns per frame; the frame commits after column NUM_COLS-1.
- CNT_W, 8: width of the dropped-frame counter.

- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- host_start  in  1  pulse; restarts the current write frame at column 0, word 0
- host_wr  in  1  host word strobe
- host_data  in  16  host word
- host_ready  out  1  a host_wr in this cycle is accepted
- frame_boundary  in  1  one-cycle pulse on the first clock of vblank (vcount==480)
- bank_wr_en  out  3  one-hot bank write strobe
- bank_wr_col  out  10  column index for the write
- bank_wr_coldata  out  42  assembled column record
- bank_wr_sf  out  16  scale factor
- rd_bank  out  2  bank the pixel pipeline reads
- status  out  16  host status: [1:0] rd_bank, [3:2] wr_bank, [5:4] pend_bank, [6] pend_valid, [7] host_ready, [15:8] drop_cnt

## Operation
- Bank state:
  - R = rd_bank, W = wr_bank, P = pend_bank plus pend_valid.
  - R ≠ W always. When pend_valid=1, R, W and P are all distinct.
- Word assembly: 4 accepted words per column, stage counter 0..3.
  - w0[9:0] → coldata[9:0]
  - w1 → coldata[25:10]
  - w2 → coldata[41:26]
  - w3 → sf
- On acceptance of w3:
  - Register a write: bank_wr_en = onehot(W), bank_wr_col = col, plus the data.
  - Then col++ and stage←0.
- Commit (w3 accepted with col == NUM_COLS-1):
  - col←0.
  - pend_valid=0: P←W, pend_valid←1, W←the third bank (not R, not W).
  - pend_valid=1, drop mode: P←W, W←old P, drop_cnt++ (saturates at all-ones).
- frame_boundary with pend_valid=1: R←P, pend_valid←0, W unchanged.
- frame_boundary with pend_valid=0: no change.
- Commit and frame_boundary in the same cycle (both evaluated on pre-edge state):
  - pend_valid=1: R←P, P←W, W←old R, pend_valid stays 1.
  - pend_valid=0: R←W, W←the third bank, pend_valid stays 0.
- host_start:
  - stage←0, col←0, partial column discarded, no bank change.
  - host_start and host_wr in the same cycle: start wins, the word is ignored.
- Reset (asynchronous, any time):
  - R=0, W=1, P=2, pend_valid=0, col=0, stage=0, drop_cnt=0.
  - bank_wr_en=0, bank_wr_col=0, bank_wr_coldata=0, bank_wr_sf=0, host_ready=1, status=0x00A4.

## Timing
- bank_wr_en is asserted exactly 1 cycle after the w3 acceptance edge, for 1 cycle.
  - Its bank index is the W value before any commit from that same word.
- Bank state and status update on the clock edge that accepts w3 or samples frame_boundary.
- rd_bank is registered and changes only on a frame_boundary edge or on reset.
- host_ready is combinational from registered state. A word is accepted when host_wr && host_ready && !host_start.
- Back-to-back words are legal every cycle, so the sustained rate is one column per 4 cycles.

## Configuration
- COLUMN_BANK_STALL_EN undefined (default): drop mode as above; host_ready is always 1.
- COLUMN_BANK_STALL_EN defined: stall mode, no frame is ever dropped.
  - host_ready=0 while stage==3, col==NUM_COLS-1 and pend_valid=1. The final word is held off until frame_boundary clears P.
  - On the frame_boundary edge that clears P, host_ready returns to 1 the following cycle.
  - drop_cnt is tied to 0.

## Structure
- Package column_pkg holds:
  - NUM_COLS default constant.
  - bank_idx_t (logic [1:0]).
  - coldata_t (logic [41:0]), sf_t (logic [15:0]).
  - Status bit-position constants.
  - third_bank(a,b) function (returns 3^a^b).
- Sub-module column_word_assembler holds the stage counter, column counter and data registers.
  - It emits col_done (w3 accepted) and frame_done (col_done at the last column).
  - The parent holds the bank state machine and drop counter.

## Test plan
- Reset → rd_bank=0, status=0x00A4, bank_wr_en=0.
- One frame of 640 columns, w0=c for column c → bank_wr_en=3'b010 with bank_wr_col=c and coldata[9:0]=c, one cycle after each w3. After column 639: pend_valid=1, P=1, W=2, rd_bank still 0.
- frame_boundary pulse after that frame → rd_bank=1, pend_valid=0, W=2.
- Two frames with no boundary:
  - Drop mode: P=2, W=1, drop_cnt=1.
  - STALL_EN: host_ready=0 at the second frame's final word until frame_boundary; then rd_bank=1, and the word is accepted, giving P=2.
- host_start after 3 words of column 5 → the next full column writes bank_wr_col=0, and the 3 old words are absent from its data.
- Commit and frame_boundary in the same cycle:
  - pend_valid=0 → rd_bank=1, W=2, pend_valid=0.
  - pend_valid=1 → R=P, P=W, W=old R.
